// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU-side request/response and RAM-side bus bundled for ram_arbiter.
// slave is the arbiter's view; master is the surrounding request unit and RAM model.
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates data (priority) and instruction requests onto a single-ported RAM.
// Define RAM_TIMEOUT_EN to add an access watchdog that enters ERR after TIMEOUT stalled cycles.
module ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          CLK,
    input logic          RST,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              wr_q;
    logic              rd_q;
    logic              timeout_hit;
    logic              ihit_c, dhit_c;

    wire d_req   = bus.dREN | bus.dWEN;
    wire ram_acc = (bus.ramstate == RAM_ACCESS);
    wire ram_err = (bus.ramstate == RAM_ERROR);

`ifdef RAM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] stall_cnt;

    // Cleared while idle so every access starts counting from zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cnt <= '0;
        else if (state == IDLE)
            stall_cnt <= '0;
        else if ((state == D_ACC || state == I_ACC) && !ram_acc)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // This stalled cycle brings the count up to TIMEOUT.
    assign timeout_hit = (stall_cnt == CNT_W'(TIMEOUT - 1));
`else
    // No watchdog: TIMEOUT only appears here so the parameter list matches both builds.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // NOTE: state is updated with <= so every process sees the pre-edge value during the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == D_ACC) begin
                addr_q  <= bus.daddr;
                store_q <= bus.dstore;
                wr_q    <= bus.dWEN;
                rd_q    <= bus.dREN & ~bus.dWEN;
            end else if (state == IDLE && next_state == I_ACC) begin
                addr_q <= bus.iaddr;
                wr_q   <= 1'b0;
                rd_q   <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        ihit_c     = 1'b0;
        dhit_c     = 1'b0;
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req)
                    next_state = D_ACC;
                else if (bus.iREN)
                    next_state = I_ACC;
            end
            D_ACC: begin
                bus.ramREN = rd_q;
                bus.ramWEN = wr_q;
                if (ram_acc) begin
                    dhit_c     = 1'b1;
                    next_state = IDLE;
                end else if (ram_err)
                    next_state = ERR;
                else if (!d_req)
                    next_state = IDLE;
                else if (timeout_hit)
                    next_state = ERR;
            end
            I_ACC: begin
                bus.ramREN = 1'b1;
                if (ram_acc) begin
                    ihit_c     = 1'b1;
                    next_state = IDLE;
                end else if (ram_err)
                    next_state = ERR;
                else if (!bus.iREN)
                    next_state = IDLE;
                else if (timeout_hit)
                    next_state = ERR;
            end
            ERR: next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    assign bus.ihit     = ihit_c;
    assign bus.dhit     = dhit_c;
    assign bus.iload    = ihit_c ? bus.ramload : '0;
    assign bus.dload    = dhit_c ? bus.ramload : '0;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = (state == ERR);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of fetch, priority, withdrawal, error, reset and watchdog.
// Inputs change 1 ns after each rising edge; outputs are sampled later in the same cycle.
module tb_ram_arbiter;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = FREE;
    endtask

    task automatic pulse_rst();
        clear_inputs();
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        bus.ramload = 32'hFFFF_0000;
        #7;
        check("rst_ihit", bus.ihit, 1'b0);
        check("rst_dhit", bus.dhit, 1'b0);
        check("rst_ren", bus.ramREN, 1'b0);
        check("rst_wen", bus.ramWEN, 1'b0);
        check("rst_addr", bus.ramaddr, 32'h0);
        check("rst_store", bus.ramstore, 32'h0);
        check("rst_iload", bus.iload, 32'h0);
        check("rst_dload", bus.dload, 32'h0);
        check("rst_err", bus.err, 1'b0);
        RST = 1'b0;

        // Instruction fetch: two BUSY cycles then ACCESS.
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h40; #1;
        check("if_req_ren", bus.ramREN, 1'b0);
        cyc(); bus.ramstate = BUSY; bus.iaddr = 32'h44; #1;
        check("if_c1_ren", bus.ramREN, 1'b1);
        check("if_c1_addr", bus.ramaddr, 32'h40);
        check("if_c1_ihit", bus.ihit, 1'b0);
        cyc(); #1;
        check("if_c2_ren", bus.ramREN, 1'b1);
        check("if_c2_addr", bus.ramaddr, 32'h40);
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h8C01_0004; #1;
        check("if_c3_ren", bus.ramREN, 1'b1);
        check("if_c3_ihit", bus.ihit, 1'b1);
        check("if_c3_iload", bus.iload, 32'h8C01_0004);
        check("if_c3_dhit", bus.dhit, 1'b0);
        cyc(); bus.ramstate = FREE; bus.iREN = 1'b0; #1;
        check("if_idle_ren", bus.ramREN, 1'b0);
        check("if_idle_ihit", bus.ihit, 1'b0);

        // Priority: data write wins over a simultaneous fetch.
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF; #1;
        check("pr_req_wen", bus.ramWEN, 1'b0);
        cyc(); bus.ramstate = ACCESS; bus.dstore = 32'h0; bus.daddr = 32'h104; #1;
        check("pr_d_wen", bus.ramWEN, 1'b1);
        check("pr_d_ren", bus.ramREN, 1'b0);
        check("pr_d_addr", bus.ramaddr, 32'h100);
        check("pr_d_store", bus.ramstore, 32'hDEAD_BEEF);
        check("pr_d_dhit", bus.dhit, 1'b1);
        check("pr_d_ihit", bus.ihit, 1'b0);
        cyc(); bus.dWEN = 1'b0; bus.ramstate = FREE; #1;
        check("pr_idle_ren", bus.ramREN, 1'b0);
        check("pr_idle_wen", bus.ramWEN, 1'b0);
        check("pr_idle_dhit", bus.dhit, 1'b0);
        // Fetch granted after one IDLE cycle; iREN dropping with ACCESS still hits.
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h0000_1234; bus.iREN = 1'b0; #1;
        check("pr_i_ren", bus.ramREN, 1'b1);
        check("pr_i_addr", bus.ramaddr, 32'h80);
        check("pr_i_ihit", bus.ihit, 1'b1);
        check("pr_i_iload", bus.iload, 32'h0000_1234);
        cyc(); bus.ramstate = FREE; #1;
        check("pr_end_ren", bus.ramREN, 1'b0);

        // Withdrawal of a data read before ACCESS.
        cyc(); bus.dREN = 1'b1; bus.daddr = 32'h200; #1;
        cyc(); bus.ramstate = BUSY; #1;
        check("wd_ren", bus.ramREN, 1'b1);
        check("wd_wen", bus.ramWEN, 1'b0);
        check("wd_addr", bus.ramaddr, 32'h200);
        cyc(); bus.dREN = 1'b0; #1;
        check("wd_drop_dhit", bus.dhit, 1'b0);
        cyc(); bus.ramstate = ACCESS; #1;
        check("wd_idle_ren", bus.ramREN, 1'b0);
        check("wd_idle_dhit", bus.dhit, 1'b0);

        // dREN and dWEN together act as a write; then a data read returns dload.
        cyc(); bus.ramstate = FREE; bus.dREN = 1'b1; bus.dWEN = 1'b1;
        bus.daddr = 32'h300; bus.dstore = 32'h0000_55AA; #1;
        cyc(); bus.ramstate = ACCESS; #1;
        check("rw_wen", bus.ramWEN, 1'b1);
        check("rw_ren", bus.ramREN, 1'b0);
        check("rw_store", bus.ramstore, 32'h0000_55AA);
        check("rw_dhit", bus.dhit, 1'b1);
        cyc(); bus.ramstate = FREE; bus.dWEN = 1'b0; bus.daddr = 32'h304; #1;
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D; #1;
        check("rd_ren", bus.ramREN, 1'b1);
        check("rd_wen", bus.ramWEN, 1'b0);
        check("rd_addr", bus.ramaddr, 32'h304);
        check("rd_dhit", bus.dhit, 1'b1);
        check("rd_dload", bus.dload, 32'hCAFE_F00D);
        cyc(); bus.ramstate = FREE; bus.dREN = 1'b0; #1;

        // RAM error during a fetch is sticky until reset.
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h50; #1;
        cyc(); bus.ramstate = ERROR; #1;
        check("er_acc_ren", bus.ramREN, 1'b1);
        check("er_acc_ihit", bus.ihit, 1'b0);
        cyc(); bus.ramstate = FREE; bus.dREN = 1'b1; #1;
        check("er_err", bus.err, 1'b1);
        check("er_ren", bus.ramREN, 1'b0);
        check("er_wen", bus.ramWEN, 1'b0);
        cyc(); bus.ramstate = ACCESS; #1;
        check("er_hold_err", bus.err, 1'b1);
        check("er_hold_dhit", bus.dhit, 1'b0);
        check("er_hold_ihit", bus.ihit, 1'b0);
        pulse_rst();
        check("er_rst_err", bus.err, 1'b0);
        cyc(); #1;
        check("er_rst_ren", bus.ramREN, 1'b0);

        // Asynchronous reset in the middle of a data write.
        cyc(); bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h99; #1;
        cyc(); bus.ramstate = BUSY; #1;
        check("ra_wen", bus.ramWEN, 1'b1);
        check("ra_addr", bus.ramaddr, 32'h400);
        check("ra_store", bus.ramstore, 32'h99);
        bus.ramstate = ACCESS; #1;
        check("ra_pre_dhit", bus.dhit, 1'b1);
        RST = 1'b1; #1;
        check("ra_dhit", bus.dhit, 1'b0);
        check("ra_wen0", bus.ramWEN, 1'b0);
        check("ra_ren0", bus.ramREN, 1'b0);
        check("ra_addr0", bus.ramaddr, 32'h0);
        check("ra_store0", bus.ramstore, 32'h0);
        check("ra_dload0", bus.dload, 32'h0);
        check("ra_err0", bus.err, 1'b0);
        clear_inputs(); #1;
        RST = 1'b0;
        cyc(); #1;
        check("ra_idle_ren", bus.ramREN, 1'b0);
        check("ra_idle_wen", bus.ramWEN, 1'b0);

`ifdef RAM_TIMEOUT_EN
        // TIMEOUT=4: four stalled access cycles lead to ERR.
        cyc(); bus.dREN = 1'b1; bus.daddr = 32'h20; #1;
        cyc(); bus.ramstate = BUSY; #1;
        repeat (3) cyc();
        check("to_c4_ren", bus.ramREN, 1'b1);
        check("to_c4_err", bus.err, 1'b0);
        cyc(); #1;
        check("to_err", bus.err, 1'b1);
        check("to_ren", bus.ramREN, 1'b0);
        pulse_rst();
        check("to_rst_err", bus.err, 1'b0);
        // ACCESS on the fourth cycle wins over the timeout.
        cyc(); bus.dREN = 1'b1; bus.daddr = 32'h24; #1;
        cyc(); bus.ramstate = BUSY; #1;
        repeat (2) cyc();
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h77; #1;
        check("to2_dhit", bus.dhit, 1'b1);
        check("to2_dload", bus.dload, 32'h77);
        check("to2_err", bus.err, 1'b0);
        cyc(); bus.dREN = 1'b0; bus.ramstate = FREE; #1;
        check("to2_after_err", bus.err, 1'b0);
        check("to2_after_ren", bus.ramREN, 1'b0);
`else
        // Without the watchdog, a long stall keeps waiting for ACCESS.
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h10; #1;
        cyc(); bus.ramstate = BUSY; #1;
        repeat (11) cyc();
        check("lw_ren", bus.ramREN, 1'b1);
        check("lw_err", bus.err, 1'b0);
        check("lw_ihit", bus.ihit, 1'b0);
        cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h0000_A5A5; #1;
        check("lw_hit", bus.ihit, 1'b1);
        check("lw_iload", bus.iload, 32'h0000_A5A5);
        cyc(); bus.iREN = 1'b0; bus.ramstate = FREE; #1;
        check("lw_idle_ren", bus.ramREN, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Memory-side responder for the CPU request unit. It accepts the instruction read request (iREN) and data read/write requests (dREN/dWEN), arbitrates them onto a single-ported RAM, and returns per-port hit pulses with load data. Data requests take priority over instruction fetch. It sits between the request unit / datapath and the RAM model, and is the only block that drives RAM enables.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- TIMEOUT, 255, maximum cycles in an access state before error (used only with RAM_TIMEOUT_EN)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- ihit  out  1  instruction access complete, one-cycle pulse
- iload  out  DATA_W  instruction word, valid while ihit=1
- dhit  out  1  data access complete, one-cycle pulse
- dload  out  DATA_W  read data, valid while dhit=1 for a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  sticky error flag

## Operation
- States: IDLE, D_ACC, I_ACC, ERR.
- IDLE: all RAM enables 0. If dREN|dWEN -> D_ACC; else if iREN -> I_ACC; else stay. Address, write data and direction are latched at the transition.
- dREN and dWEN both 1: treated as a write.
- D_ACC: ramWEN=latched write, ramREN=latched read, ramaddr=latched daddr, ramstore=latched dstore. When ramstate==ACCESS: dhit=1 and dload=ramload in the same cycle, then go to IDLE.
- I_ACC: ramREN=1, ramaddr=latched iaddr. When ramstate==ACCESS: ihit=1 and iload=ramload, then go to IDLE.
- Withdrawal: if the owning request drops (dREN=dWEN=0 in D_ACC, or iREN=0 in I_ACC) before ACCESS, the access is aborted and the state returns to IDLE next cycle with no hit. If ACCESS and the drop occur in the same cycle, the hit is still issued.
- ramstate==ERROR in either access state -> ERR. In ERR, err=1 and enables are 0. ERR is exited only by RST.
- ihit and dhit are never 1 in the same cycle.
- Reset values: state IDLE; ihit=dhit=0; ramREN=ramWEN=0; ramaddr=0; ramstore=0; iload=dload=0; err=0.
- RST asserted mid-access drops the enables immediately (asynchronous). No hit is issued.

## Timing
- A request sampled in IDLE at edge n drives RAM enables from cycle n+1.
- The hit occurs combinationally in the first access-state cycle in which ramstate==ACCESS.
- Minimum round trip is 2 cycles (request cycle plus one access cycle).
- After a hit, the arbiter spends exactly one cycle in IDLE before it can grant again. A still-pending iREN is granted on the next edge.
- Enables and address are stable for the whole access state. Latched values ignore input changes after grant.

## Configuration
- RAM_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to D_ACC or I_ACC and increments each access cycle without ACCESS.
  - When the count reaches TIMEOUT, the next state is ERR and err is set.
  - ACCESS in the same cycle as the count reaching TIMEOUT wins: the hit is issued and there is no error.
- RAM_TIMEOUT_EN undefined: there is no counter, and an access waits indefinitely for ACCESS or ERROR.

## Test plan
- Instruction fetch: iREN=1, iaddr=0x40, ramstate=ACCESS after 2 BUSY cycles, ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 for 3 cycles; ihit pulses once with iload=0x8C010004; then IDLE.
- Priority: iREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF in the same cycle -> D_ACC first with ramWEN=1 and ramstore=0xDEADBEEF; dhit follows; then I_ACC starts one cycle after IDLE.
- Withdrawal: dREN=1 granted, then dREN=0 while ramstate=BUSY -> IDLE next cycle, dhit never asserted.
- Error: ramstate=ERROR during I_ACC -> err=1, enables 0, requests ignored until RST pulse, after which err=0 and the state is IDLE.
- Reset mid-access: RST asserted during D_ACC -> ramREN, ramWEN and dhit go to 0 without waiting for a clock edge; all outputs take their reset values.
- RAM_TIMEOUT_EN with TIMEOUT=4: ramstate held BUSY -> ERR after 4 access cycles. A second run with ACCESS on cycle 4 -> dhit is issued and err stays 0.
